rf_operand_collector: RTL and testbench

//  Operand-collect stage directly upstream of the banked register-file BRAMs
//  (dual-port, 1-cycle registered read). Accepts one issued warp instruction,

---
 rtl/rf_operand_collector.sv | 192 +++++++++++++++++++
 tb/tb_rf_operand_collector.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_operand_collector.sv
// Operand collector: latches one issued instruction, reads up to two sources from the banked RF, dispatches to execute.
// Accept->ex_valid is 3 cycles (4 on a same-bank conflict); iss_ready low while busy, DISP holds while ex_ready is low.
module rf_operand_collector #(
  parameter  int DATA      = 256,
  parameter  int ADDR      = 3,
  parameter  int BANK_W    = 2,
  parameter  int TAG       = 16,
  localparam int NUM_BANKS = 2**BANK_W,
  localparam int RN        = ADDR + BANK_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iss_valid,
  output logic                      iss_ready,
  input  logic [RN-1:0]             iss_src0,
  input  logic [RN-1:0]             iss_src1,
  input  logic                      iss_src1_en,
  input  logic [TAG-1:0]            iss_tag,
  output logic [NUM_BANKS-1:0]      rf_rd_en,
  output logic [NUM_BANKS*ADDR-1:0] rf_rd_addr,
  input  logic [NUM_BANKS*DATA-1:0] rf_rd_data,
  input  logic                      wb_en,
  input  logic [RN-1:0]             wb_reg,
  input  logic [DATA-1:0]           wb_data,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA-1:0]           ex_op0,
  output logic [DATA-1:0]           ex_op1,
  output logic [TAG-1:0]            ex_tag
);

  typedef enum logic [1:0] {IDLE, READ, CAP, DISP} state_t;

  typedef struct packed {
    logic [RN-1:0] src0;
    logic [RN-1:0] src1;
    logic          src1_en;
    logic          same;
  } instr_t;

  function automatic logic [BANK_W-1:0] bank_of(input logic [RN-1:0] r);
    return r[BANK_W-1:0];
  endfunction

  function automatic logic [ADDR-1:0] row_of(input logic [RN-1:0] r);
    return r[RN-1:BANK_W];
  endfunction

  function automatic logic [NUM_BANKS-1:0] bank_oh(input logic [RN-1:0] r);
    return NUM_BANKS'(1) << bank_of(r);
  endfunction

  function automatic logic [NUM_BANKS*ADDR-1:0] addr_at(input logic [RN-1:0] r);
    logic [NUM_BANKS*ADDR-1:0] v;
    v = '0;
    v[int'(bank_of(r))*ADDR +: ADDR] = row_of(r);
    return v;
  endfunction

  state_t          state;
  instr_t          ins_q;
  logic            iss_rdy_q;
  logic            pend;
  logic            rd0_q;
  logic            rd1_q;
  logic            fwd0;
  logic            fwd1;
  logic [DATA-1:0] fwd0_dat;
  logic [DATA-1:0] fwd1_dat;

  logic            iss_same;
  logic            iss_conf;
  logic            iss_dual;
  logic            wb_hit0;
  logic            wb_hit1;
  logic [DATA-1:0] rd_dat0;
  logic [DATA-1:0] rd_dat1;
  logic [DATA-1:0] cap0;
  logic [DATA-1:0] cap1;

  assign iss_ready = iss_rdy_q & ~rst;

  // Identical registers collapse to one read; same bank with a different row must be serialised.
  assign iss_same = iss_src1_en && (iss_src1 == iss_src0);
  assign iss_conf = iss_src1_en && !iss_same && (bank_of(iss_src1) == bank_of(iss_src0));
  assign iss_dual = iss_src1_en && !iss_same && !iss_conf;

  assign wb_hit0 = wb_en && (wb_reg == ins_q.src0);
  assign wb_hit1 = wb_en && (wb_reg == ins_q.src1);

  assign rd_dat0 = rf_rd_data[int'(bank_of(ins_q.src0))*DATA +: DATA];
  assign rd_dat1 = rf_rd_data[int'(bank_of(ins_q.src1))*DATA +: DATA];
  assign cap0    = fwd0 ? fwd0_dat : rd_dat0;
  assign cap1    = fwd1 ? fwd1_dat : rd_dat1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ins_q      <= '0;
      iss_rdy_q  <= 1'b1;
      pend       <= 1'b0;
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
      fwd0       <= 1'b0;
      fwd1       <= 1'b0;
      fwd0_dat   <= '0;
      fwd1_dat   <= '0;
      rf_rd_en   <= '0;
      rf_rd_addr <= '0;
      ex_valid   <= 1'b0;
      ex_op0     <= '0;
      ex_op1     <= '0;
      ex_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iss_valid) begin
            ins_q.src0    <= iss_src0;
            ins_q.src1    <= iss_src1;
            ins_q.src1_en <= iss_src1_en;
            ins_q.same    <= iss_same;
            pend          <= iss_conf;
            fwd0          <= 1'b0;
            fwd1          <= 1'b0;
            rf_rd_en      <= bank_oh(iss_src0) | (iss_dual ? bank_oh(iss_src1) : '0);
            rf_rd_addr    <= addr_at(iss_src0) | (iss_dual ? addr_at(iss_src1) : '0);
            ex_tag        <= iss_tag;
            iss_rdy_q     <= 1'b0;
            state         <= READ;
          end
        end

        READ: begin
          // The BRAM returns pre-write data for a same-edge write, so catch it here.
          if (wb_hit0) begin
            fwd0     <= 1'b1;
            fwd0_dat <= wb_data;
          end
          if (ins_q.src1_en && !pend && wb_hit1) begin
            fwd1     <= 1'b1;
            fwd1_dat <= wb_data;
          end
          rd0_q <= 1'b1;
          rd1_q <= ins_q.src1_en && !pend && !ins_q.same;
          if (pend) begin
            rf_rd_en   <= bank_oh(ins_q.src1);
            rf_rd_addr <= addr_at(ins_q.src1);
          end else begin
            rf_rd_en   <= '0;
            rf_rd_addr <= '0;
          end
          state <= CAP;
        end

        CAP: begin
          if (rd0_q) ex_op0 <= cap0;
          if (!ins_q.src1_en)  ex_op1 <= '0;
          else if (ins_q.same) ex_op1 <= cap0;
          else if (rd1_q)      ex_op1 <= cap1;

          if (pend) begin
            if (wb_hit1) begin
              fwd1     <= 1'b1;
              fwd1_dat <= wb_data;
            end
            pend       <= 1'b0;
            rd0_q      <= 1'b0;
            rd1_q      <= 1'b1;
            rf_rd_en   <= '0;
            rf_rd_addr <= '0;
          end else begin
            rd0_q    <= 1'b0;
            rd1_q    <= 1'b0;
            ex_valid <= 1'b1;
            state    <= DISP;
          end
        end

        DISP: begin
          if (ex_ready) begin
            ex_valid  <= 1'b0;
            iss_rdy_q <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_operand_collector.sv
// Bench for rf_operand_collector: BRAM bank model, scoreboard of expected dispatches, vector table plus corner sequences.
module tb_rf_operand_collector;
  localparam int DATA = 256, ADDR = 3, BANK_W = 2, TAG = 16, NB = 4, RN = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [RN-1:0]        iss_src0;
  logic [RN-1:0]        iss_src1;
  logic                 iss_src1_en;
  logic [TAG-1:0]       iss_tag;
  logic [NB-1:0]        rf_rd_en;
  logic [NB*ADDR-1:0]   rf_rd_addr;
  logic [NB*DATA-1:0]   rf_rd_data;
  logic                 wb_en;
  logic [RN-1:0]        wb_reg;
  logic [DATA-1:0]      wb_data;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [DATA-1:0]      ex_op0;
  logic [DATA-1:0]      ex_op1;
  logic [TAG-1:0]       ex_tag;

  always #5 clk = ~clk;

  rf_operand_collector #(.DATA(DATA), .ADDR(ADDR), .BANK_W(BANK_W), .TAG(TAG)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src0(iss_src0), .iss_src1(iss_src1),
    .iss_src1_en(iss_src1_en), .iss_tag(iss_tag),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op0(ex_op0), .ex_op1(ex_op1), .ex_tag(ex_tag)
  );

  // Read-first dual-port banks: port A registered read, port B write.
  logic [DATA-1:0]    mem [NB][8];
  logic [NB*DATA-1:0] rd_q;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (rf_rd_en[b]) rd_q[b*DATA +: DATA] <= mem[b][rf_rd_addr[b*ADDR +: ADDR]];
    if (wb_en) mem[wb_reg[1:0]][wb_reg[4:2]] <= wb_data;
  end
  assign rf_rd_data = rd_q;

  typedef struct {
    logic [DATA-1:0] op0;
    logic [DATA-1:0] op1;
    logic [TAG-1:0]  tag;
    int              lat;
  } exp_t;

  typedef struct {
    int               c;
    logic [NB-1:0]    en;
    logic [NB*ADDR-1:0] addr;
  } rd_t;

  typedef struct {
    int s0;
    int s1;
    bit en;
    int lat;
  } vec_t;

  exp_t            sb[$];
  rd_t             rd_log[$];
  logic [DATA-1:0] ref_m [32];
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              acc_cyc = 0;
  int              lat_meas = 0;
  int              idle_addr_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor on the falling edge: accept/latency tracking, read log, scoreboard pops.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (iss_valid && iss_ready) acc_cyc = cyc;
      if (ex_valid && !prev_v) lat_meas = cyc - acc_cyc;
      prev_v = ex_valid;
      if (rf_rd_en != 0) rd_log.push_back('{cyc, rf_rd_en, rf_rd_addr});
      else if (rf_rd_addr != 0) idle_addr_bad++;
      if (ex_valid && ex_ready) begin
        if (sb.size() == 0) chk("unexpected_dispatch", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ex_op0", ex_op0, e.op0);
          chk("ex_op1", ex_op1, e.op1);
          chk("ex_tag", DATA'(ex_tag), DATA'(e.tag));
          chk("latency", DATA'(lat_meas), DATA'(e.lat));
        end
      end
    end
  end

  task automatic wr(input int r, input logic [DATA-1:0] d);
    wb_en = 1'b1; wb_reg = RN'(r); wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
    ref_m[r] = d;
  endtask

  task automatic do_issue(input int s0, input int s1, input bit en, input logic [TAG-1:0] tg,
                          input logic [DATA-1:0] e0, input logic [DATA-1:0] e1,
                          input int lat, input bit push);
    int n;
    if (push) sb.push_back('{e0, e1, tg, lat});
    iss_valid = 1'b1; iss_src0 = RN'(s0); iss_src1 = RN'(s1); iss_src1_en = en; iss_tag = tg;
    n = 0;
    @(negedge clk);
    while (!iss_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("issue_timeout", 0, 1);
    @(posedge clk); #1;
    iss_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ex_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  function automatic logic [DATA-1:0] rnd_word();
    logic [DATA-1:0] d;
    for (int t = 0; t < 8; t++) d[t*32 +: 32] = $urandom();
    return d;
  endfunction

  initial begin
    vec_t            tbl[8];
    logic [DATA-1:0] d, cafe;
    int              n, seen;

    tbl[0] = '{1, 6, 1'b1, 3};
    tbl[1] = '{1, 5, 1'b1, 4};
    tbl[2] = '{9, 9, 1'b1, 3};
    tbl[3] = '{2, 3, 1'b0, 3};
    tbl[4] = '{0, 4, 1'b1, 4};
    tbl[5] = '{31, 30, 1'b1, 3};
    tbl[6] = '{7, 31, 1'b1, 4};
    tbl[7] = '{12, 12, 1'b0, 3};

    rst = 1'b1; iss_valid = 1'b0; iss_src0 = '0; iss_src1 = '0; iss_src1_en = 1'b0; iss_tag = '0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; ex_ready = 1'b1;

    @(negedge clk);
    chk("iss_ready_in_rst", DATA'(iss_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", DATA'(ex_valid), 0);
    chk("rst_ex_op0", ex_op0, 0);
    chk("rst_ex_op1", ex_op1, 0);
    chk("rst_ex_tag", DATA'(ex_tag), 0);
    chk("rst_rd_en", DATA'(rf_rd_en), 0);
    chk("iss_ready_rst_held", DATA'(iss_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("iss_ready_after_rst", DATA'(iss_ready), 1);
    @(posedge clk); #1;

    for (int r = 0; r < 32; r++) wr(r, rnd_word());
    d = {8{32'h0000_00A1}}; wr(1, d);
    d = {8{32'h0000_00B6}}; wr(6, d);

    // Vector table with back-to-back handshakes.
    for (int i = 0; i < 8; i++) begin
      do_issue(tbl[i].s0, tbl[i].s1, tbl[i].en, TAG'(16'h100 + i), ref_m[tbl[i].s0],
               tbl[i].en ? ref_m[tbl[i].s1] : '0, tbl[i].lat, 1'b1);
      wait_drain();
    end

    // Conflict on bank 1: two single-bank reads in consecutive cycles.
    rd_log.delete();
    do_issue(1, 5, 1'b1, 16'h200, ref_m[1], ref_m[5], 4, 1'b1);
    wait_drain();
    chk("conf_nreads", DATA'(rd_log.size()), 2);
    if (rd_log.size() == 2) begin
      chk("conf_rd0_en", DATA'(rd_log[0].en), 4'b0010);
      chk("conf_rd0_addr", DATA'(rd_log[0].addr), 12'h000);
      chk("conf_rd1_en", DATA'(rd_log[1].en), 4'b0010);
      chk("conf_rd1_addr", DATA'(rd_log[1].addr), 12'h008);
      chk("conf_consecutive", DATA'(rd_log[1].c - rd_log[0].c), 1);
    end

    // Identical sources: one read, bank 1 row 2.
    rd_log.delete();
    do_issue(9, 9, 1'b1, 16'h201, ref_m[9], ref_m[9], 3, 1'b1);
    wait_drain();
    chk("same_nreads", DATA'(rd_log.size()), 1);
    if (rd_log.size() == 1) begin
      chk("same_rd_en", DATA'(rd_log[0].en), 4'b0010);
      chk("same_rd_addr", DATA'(rd_log[0].addr), 12'h010);
    end

    // Writeback in the READ cycle is forwarded.
    cafe = {8{32'hCAFE_F00D}};
    do_issue(1, 6, 1'b1, 16'h300, ref_m[1], cafe, 3, 1'b1);
    wr(6, cafe);
    wait_drain();

    // Writeback during the deferred src1 read is forwarded too.
    d = rnd_word();
    do_issue(1, 5, 1'b1, 16'h301, ref_m[1], d, 4, 1'b1);
    @(posedge clk); #1;
    wr(5, d);
    wait_drain();

    // Writeback after the read cycle is not seen.
    d = rnd_word();
    do_issue(2, 3, 1'b1, 16'h302, ref_m[2], ref_m[3], 3, 1'b1);
    @(posedge clk); #1;
    wr(2, d);
    wait_drain();

    // Writeback landing on the accept edge is visible through the BRAM.
    d = rnd_word();
    wb_en = 1'b1; wb_reg = 5'd7; wb_data = d;
    do_issue(7, 0, 1'b1, 16'h303, d, ref_m[0], 3, 1'b1);
    wb_en = 1'b0;
    ref_m[7] = d;
    wait_drain();

    // src1 unused, execute stalled for five cycles.
    ex_ready = 1'b0;
    do_issue(3, 4, 1'b0, 16'h400, ref_m[3], '0, 3, 1'b1);
    n = 0;
    while (!ex_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_ex_valid", DATA'(ex_valid), 1);
      chk("hold_iss_ready", DATA'(iss_ready), 0);
      chk("hold_op0", ex_op0, ref_m[3]);
      chk("hold_op1", ex_op1, 0);
    end
    @(posedge clk); #1;
    ex_ready = 1'b1;
    wait_drain();
    do_issue(4, 10, 1'b1, 16'h401, ref_m[4], ref_m[10], 3, 1'b1);
    wait_drain();

    // Reset while capturing drops the instruction.
    do_issue(1, 6, 1'b1, 16'h500, '0, '0, 3, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_iss_ready", DATA'(iss_ready), 1);
    chk("midrst_rd_en", DATA'(rf_rd_en), 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (ex_valid) seen++;
      @(negedge clk);
    end
    chk("midrst_no_dispatch", DATA'(seen), 0);
    @(posedge clk); #1;
    do_issue(1, 6, 1'b1, 16'h501, ref_m[1], ref_m[6], 3, 1'b1);
    wait_drain();

    chk("idle_addr_nonzero", DATA'(idle_addr_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
